// File: rtl/tns_rx_checker_24.sv
// tns_rx_checker_24
// Receive-side checker for the 24-TSV TNS crosstalk-avoidance link.
// Stage 1 captures the TSV word, stage 2 decodes it, checks each 3-TSV group
// against the previous line state and registers the payload and error flags.
// A saturating counter tracks erroneous words for link-health monitoring.
//
// Ports:
//   clock      - sole clock, rising edge
//   reset      - asynchronous active-high reset
//   tsv        - received TSV word, group j = tsv[3j+2:3j]
//   tsv_valid  - tsv carries a codeword this cycle
//   clr_cnt    - synchronous clear of err_count (wins over a coincident error)
//   dataout    - decoded payload, holds between words
//   data_valid - one-cycle pulse per accepted word
//   rule_err   - transition-rule violation in any group (qualified by data_valid)
//   range_err  - decoded value >= TNS09_C (qualified by data_valid)
//   err_group  - per-group transition-rule violation flags
//   err_count  - saturating count of erroneous words
module tns_rx_checker_24 #(
    parameter int unsigned ERRCNT_W = 16,
    parameter int unsigned BLEN08   = 14,
    parameter int unsigned TNS09_C  = 6561
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [23:0]         tsv,
    input  logic                tsv_valid,
    input  logic                clr_cnt,
    output logic [BLEN08-1:0]   dataout,
    output logic                data_valid,
    output logic                rule_err,
    output logic                range_err,
    output logic [7:0]          err_group,
    output logic [ERRCNT_W-1:0] err_count
);

    // TNS_dec_24: each group's low two TSVs carry a base-3 digit (group 0 is the
    // least significant); the top TSV only steers the line transitions. Digit
    // value 3 never comes from the encoder but is decoded as-is so that corrupt
    // words can land at or above TNS09_C.
    function automatic int unsigned tns_dec_24(input logic [23:0] w);
        int unsigned acc;
        acc = 0;
        for (int j = 7; j >= 0; j--) begin
            acc = acc * 3 + 32'(w[3*j +: 2]);
        end
        return acc;
    endfunction

    logic [23:0]         tsv_r_q, tsv_r_d;
    logic                v1_q;
    logic [7:0]          rbit_q, rbit_d;
    logic [BLEN08-1:0]   dataout_q, dataout_d;
    logic                data_valid_q, data_valid_d;
    logic                rule_err_q, rule_err_d;
    logic                range_err_q, range_err_d;
    logic [7:0]          err_group_q, err_group_d;
    logic [ERRCNT_W-1:0] err_count_q, err_count_d;

    int unsigned         dec_val;
    logic [7:0]          grp_viol;
    logic                word_err;

    always_comb begin
        tsv_r_d = tsv_valid ? tsv : tsv_r_q;
    end

    // Group pattern {tsv[3j+2], tsv[3j+1], tsv[3j]}: 100 after a low top line and
    // 011 after a high top line are the forbidden transitions.
    always_comb begin
        grp_viol = '0;
        for (int j = 0; j < 8; j++) begin
            grp_viol[j] = ((tsv_r_q[3*j +: 3] == 3'b100) && !rbit_q[j]) ||
                          ((tsv_r_q[3*j +: 3] == 3'b011) &&  rbit_q[j]);
        end
    end

    always_comb begin
        dec_val      = tns_dec_24(tsv_r_q);
        dataout_d    = dataout_q;
        data_valid_d = v1_q;
        rule_err_d   = 1'b0;
        range_err_d  = 1'b0;
        err_group_d  = '0;
        rbit_d       = rbit_q;
        if (v1_q) begin
            dataout_d   = dec_val[BLEN08-1:0];
            err_group_d = grp_viol;
            rule_err_d  = |grp_viol;
            range_err_d = (dec_val >= TNS09_C);
            // History follows the physical line, erroneous words included.
            for (int j = 0; j < 8; j++) begin
                rbit_d[j] = tsv_r_q[3*j+2];
            end
        end
    end

    always_comb begin
        word_err    = v1_q && ((|grp_viol) || (dec_val >= TNS09_C));
        err_count_d = err_count_q;
        if (clr_cnt) begin
            err_count_d = '0;
        end else if (word_err && (err_count_q != {ERRCNT_W{1'b1}})) begin
            err_count_d = err_count_q + ERRCNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tsv_r_q      <= '0;
            v1_q         <= 1'b0;
            rbit_q       <= '0;
            dataout_q    <= '0;
            data_valid_q <= 1'b0;
            rule_err_q   <= 1'b0;
            range_err_q  <= 1'b0;
            err_group_q  <= '0;
            err_count_q  <= '0;
        end else begin
            tsv_r_q      <= tsv_r_d;
            v1_q         <= tsv_valid;
            rbit_q       <= rbit_d;
            dataout_q    <= dataout_d;
            data_valid_q <= data_valid_d;
            rule_err_q   <= rule_err_d;
            range_err_q  <= range_err_d;
            err_group_q  <= err_group_d;
            err_count_q  <= err_count_d;
        end
    end

    assign dataout    = dataout_q;
    assign data_valid = data_valid_q;
    assign rule_err   = rule_err_q;
    assign range_err  = range_err_q;
    assign err_group  = err_group_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_tns_rx_checker_24.sv
// Bench for tns_rx_checker_24: scoreboard of expected words pushed when driven,
// popped when data_valid appears. A second instance with a 2-bit counter covers
// saturation.
module tb_tns_rx_checker_24;

    localparam int unsigned LIMIT = 6561;

    typedef struct packed {
        logic [13:0] data;
        logic        rule;
        logic        range;
        logic [7:0]  grp;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [23:0] tsv;
    logic        tsv_valid;
    logic        clr_cnt;

    logic [13:0] dataout_a, dataout_b;
    logic        dv_a, dv_b, rule_a, rule_b, range_a, range_b;
    logic [7:0]  grp_a, grp_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    tns_rx_checker_24 #(.ERRCNT_W(16)) dut (
        .clock(clock), .reset(reset), .tsv(tsv), .tsv_valid(tsv_valid), .clr_cnt(clr_cnt),
        .dataout(dataout_a), .data_valid(dv_a), .rule_err(rule_a), .range_err(range_a),
        .err_group(grp_a), .err_count(cnt_a)
    );

    tns_rx_checker_24 #(.ERRCNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .tsv(tsv), .tsv_valid(tsv_valid), .clr_cnt(clr_cnt),
        .dataout(dataout_b), .data_valid(dv_b), .rule_err(rule_b), .range_err(range_b),
        .err_group(grp_b), .err_count(cnt_b)
    );

    always #5 clock = ~clock;

    int          tests = 0;
    int          fails = 0;
    exp_t        q[$];
    logic [7:0]  m_rbit;
    int unsigned m_cnt16, m_cnt2;
    logic [13:0] m_last;
    logic        pend_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: base-3 digits in the low TSVs; the top TSV holds when
    // the digit is 0 and toggles otherwise, which never forms a forbidden pattern.
    function automatic logic [23:0] encode(input int unsigned v, input logic [7:0] rb);
        logic [23:0] w;
        int unsigned r, d;
        w = '0;
        r = v;
        for (int j = 0; j < 8; j++) begin
            d = r % 3;
            r = r / 3;
            w[3*j +: 2] = 2'(d);
            w[3*j+2]    = (d == 0) ? rb[j] : ~rb[j];
        end
        return w;
    endfunction

    task automatic push(input logic [23:0] w);
        exp_t        e;
        int unsigned val, p;
        logic [2:0]  g;
        val = 0;
        p   = 1;
        e   = '0;
        for (int j = 0; j < 8; j++) begin
            g = w[3*j +: 3];
            val += 32'(g[1:0]) * p;
            p   *= 3;
            e.grp[j] = (g == 3'b100 && !m_rbit[j]) || (g == 3'b011 && m_rbit[j]);
            m_rbit[j] = g[2];
        end
        e.data  = val[13:0];
        e.rule  = |e.grp;
        e.range = (val >= LIMIT);
        q.push_back(e);
    endtask

    // One cycle: drive, clock, check the word now leaving stage 2 (if any).
    task automatic step(input logic [23:0] t, input logic v, input logic clr);
        exp_t e;
        logic err;
        tsv       = t;
        tsv_valid = v;
        clr_cnt   = clr;
        @(posedge clock);
        #1;
        err = 1'b0;
        if (pend_v) begin
            chk("dv", {31'b0, dv_a}, 32'd1);
            chk("dv_sat", {31'b0, dv_b}, 32'd1);
            if (q.size() == 0) begin
                chk("queue_empty", 32'd0, 32'd1);
            end else begin
                e = q.pop_front();
                chk("data", {18'b0, dataout_a}, {18'b0, e.data});
                chk("rule", {31'b0, rule_a}, {31'b0, e.rule});
                chk("range", {31'b0, range_a}, {31'b0, e.range});
                chk("grp", {24'b0, grp_a}, {24'b0, e.grp});
                m_last = e.data;
                err    = e.rule | e.range;
            end
        end else begin
            chk("idle_dv", {31'b0, dv_a}, 32'd0);
            chk("idle_flags", {22'b0, rule_a, range_a, grp_a}, 32'd0);
            chk("idle_hold", {18'b0, dataout_a}, {18'b0, m_last});
        end
        if (clr) begin
            m_cnt16 = 0;
            m_cnt2  = 0;
        end else if (err) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        chk("cnt16", {16'b0, cnt_a}, m_cnt16);
        chk("cnt2", {30'b0, cnt_b}, m_cnt2);
        if (v) push(t);
        pend_v = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_out_a", {dataout_a, dv_a, rule_a, range_a, grp_a}, 32'd0);
        chk("rst_cnt_a", {16'b0, cnt_a}, 32'd0);
        chk("rst_out_b", {dataout_b, dv_b, rule_b, range_b, grp_b}, 32'd0);
        chk("rst_cnt_b", {30'b0, cnt_b}, 32'd0);
        q.delete();
        m_rbit  = '0;
        m_cnt16 = 0;
        m_cnt2  = 0;
        m_last  = '0;
        pend_v  = 1'b0;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        tsv       = '0;
        tsv_valid = 1'b0;
        clr_cnt   = 1'b0;
        #1;
        do_reset();

        // Rule 001 after 0
        step(24'h000004, 1'b1, 1'b0);
        step(24'h000000, 1'b0, 1'b0);
        chk("t3_rule", {31'b0, rule_a}, 32'd1);
        chk("t3_grp", {24'b0, grp_a}, 32'h01);
        chk("t3_cnt", {16'b0, cnt_a}, 32'd1);

        // Reset mid-stream with words in flight
        step(encode(123, m_rbit), 1'b1, 1'b0);
        step(encode(4000, m_rbit), 1'b1, 1'b0);
        do_reset();

        // Rule 110 after 1; first step also confirms no data_valid for discarded words
        step(24'h000038, 1'b1, 1'b0);
        step(24'h000018, 1'b1, 1'b0);
        chk("t4_first_rule", {31'b0, rule_a}, 32'd0);
        chk("t4_first_data", {18'b0, dataout_a}, 32'd9);
        step(24'h000000, 1'b0, 1'b0);
        chk("t4_rule", {31'b0, rule_a}, 32'd1);
        chk("t4_grp", {24'b0, grp_a}, 32'h02);

        // Gap keeps history
        step(24'h000038, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(24'($urandom), 1'b0, 1'b0);
        step(24'h000018, 1'b1, 1'b0);
        step(24'h000000, 1'b0, 1'b0);
        chk("t5_grp", {24'b0, grp_a}, 32'h02);

        // Range boundary: 3*3^7 = 6561 is the first out-of-range value
        step(24'hE00000, 1'b1, 1'b0);
        step(encode(LIMIT - 1, m_rbit), 1'b1, 1'b0);
        chk("range_at_limit", {31'b0, range_a}, 32'd1);
        chk("data_at_limit", {18'b0, dataout_a}, LIMIT);
        step(24'h000000, 1'b0, 1'b0);
        chk("range_below", {31'b0, range_a}, 32'd0);

        // Round trip
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            step(encode($urandom_range(0, LIMIT - 1), m_rbit), 1'b1, 1'b0);
        end
        step(24'h000000, 1'b0, 1'b0);
        chk("rt_cnt", {16'b0, cnt_a}, 32'd0);

        // Saturation and clear (2-bit counter)
        do_reset();
        step(24'h000004, 1'b1, 1'b0);
        step(24'h000003, 1'b1, 1'b0);
        step(24'h000004, 1'b1, 1'b0);
        step(24'h000003, 1'b1, 1'b0);
        step(24'h000004, 1'b1, 1'b0);
        step(24'h000003, 1'b1, 1'b0);
        chk("sat_cnt", {30'b0, cnt_b}, 32'd3);
        // Clear lands on the same edge that registers the sixth erroneous word
        step(24'h000000, 1'b0, 1'b1);
        chk("clr_rule", {31'b0, rule_b}, 32'd1);
        chk("clr_cnt2", {30'b0, cnt_b}, 32'd0);
        chk("clr_cnt16", {16'b0, cnt_a}, 32'd0);
        step(24'h000000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tns_rx_checker_24.md
# tns_rx_checker_24

Registered receive-side checker for the 24-TSV TNS crosstalk-avoidance link, at the far end of the TSV bundle driven by `TNS_encoder_24`. Samples the 24-bit TSV word and recovers the `BLEN08`-bit payload through an internal `TNS_dec_24` instance. Tracks the previous line state per 3-TSV group to flag transition-rule violations and out-of-range codewords. Keeps a saturating error counter for link-health monitoring.

## Interface
- `ERRCNT_W`, default 16: width of the error counter.
- `clock`, input, 1: sole clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `tsv`, input, 24: received TSV word. Group j is {`tsv[3j+2]`, `tsv[3j+1]`, `tsv[3j]`}, j = 0..7.
- `tsv_valid`, input, 1: `tsv` carries a codeword this cycle.
- `clr_cnt`, input, 1: synchronous clear of `err_count`.
- `dataout`, output, `BLEN08`: decoded payload.
- `data_valid`, output, 1: one-cycle pulse per accepted word.
- `rule_err`, output, 1: the word violated the transition rule in at least one group. Qualified by `data_valid`.
- `range_err`, output, 1: decoded value ≥ `TNS09_C`. Qualified by `data_valid`.
- `err_group`, output, 8: bit j set when group j violated the transition rule.
- `err_count`, output, `ERRCNT_W`: saturating count of erroneous words.

## Operation
- **Stage 1 (capture).** On each rising edge, `tsv_r` ← `tsv` and `v1` ← `tsv_valid`. `tsv_r` loads only when `tsv_valid` is 1; otherwise it holds.
- **Stage 2 (decode/check).** When `v1` is 1:
  - `tsv_r` is decoded combinationally by `TNS_dec_24`.
  - `dataout`, the error flags and `data_valid` are registered from the result.
- **History state.** `rbit[7:0]` holds `tsv[3j+2]` of the last accepted word. Reset value is all zeros, which matches the encoder's idle line.
- **Rule check for group j** against `rbit[j]`:
  - Pattern 001 (`tsv[3j]`=0, `tsv[3j+1]`=0, `tsv[3j+2]`=1) with `rbit[j]`=0 is a violation.
  - Pattern 110 with `rbit[j]`=1 is a violation.
  - All other combinations are legal.
- `rule_err` is the OR of `err_group`.
- `range_err` = (decoded value ≥ `TNS09_C`). `dataout` still presents the raw decoded value.
- `rbit` updates from every accepted word, including erroneous ones, so the checker keeps tracking the physical line.
- **Counter.**
  - `err_count` increments by 1 per accepted word with `rule_err` or `range_err` set. A word with both errors counts once.
  - The counter saturates at 2^`ERRCNT_W`−1.
- `clr_cnt` forces `err_count` to 0 on the next edge. If it coincides with an erroring word, the clear wins and that event is not counted.
- There is no backpressure. The block accepts one word per cycle indefinitely.

## Timing
- **Reset values** (async on `reset` high): `tsv_r`=0, `v1`=0, `rbit`=0, `dataout`=0, `data_valid`=0, `rule_err`=0, `range_err`=0, `err_group`=0, `err_count`=0.
- **Latency.** A word with `tsv_valid` high sampled at edge k appears on the outputs after edge k+1, with `data_valid` high for exactly that cycle. Two-cycle latency, full throughput.
- **Cycles without an accepted word:**
  - `data_valid`, `rule_err`, `range_err` and `err_group` are 0.
  - `dataout` holds its last value.
  - `rbit` and `err_count` are unchanged.
- **Gaps.** `tsv_valid` low between words does not reset history. The check for the next word uses the last accepted word's `rbit`.
- **Reset mid-stream.** Words in flight are discarded and `rbit` returns to 0. The first word after reset is checked against all-zero history.
- **Deassertion.** Reset deassertion is synchronised externally. The first sampling edge is the first edge after `reset` falls.

## Test plan
1. **Reset.** Assert `reset` mid-stream with `tsv_valid`=1 → all outputs are 0 immediately. No `data_valid` follows for words that were in flight.
2. **Round trip.** `TNS_encoder_24` drives `tsv` with 100000 random values in [0, `TNS09_C`−1] and `tsv_valid`=1 every cycle → `dataout` equals the input two cycles later. `rule_err`=`range_err`=0 throughout; `err_count`=0.
3. **Rule 001 after 0.** After reset, send `tsv`=24'h000004 → `rule_err`=1, `err_group`=8'h01, `err_count`=1.
4. **Rule 110 after 1.** After reset, send 24'h000038 (group 1 = 111, legal), then 24'h000018 (group 1 = 110 with `rbit[1]`=1) → first word clean. Second word has `rule_err`=1 and `err_group`=8'h02.
5. **Gaps.** Send 24'h000038, hold `tsv_valid`=0 for 5 cycles with random `tsv`, then send 24'h000018 → no `data_valid` during the gap. The final word is flagged with `err_group`=8'h02.
6. **Saturation/clear.** With `ERRCNT_W`=2, send five erroneous words → `err_count` sticks at 3. Then assert `clr_cnt` together with a sixth erroneous word → `err_count`=0 and `rule_err`=1 on that word.
